// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one DATA_W-bit adder among NUM_REQ requesters.
// One grant per cycle into a registered response slot that refills as it drains.
module adder_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 32,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic                      rsp_carry,
    output logic [ID_W-1:0]           rsp_id
);

    // Circular index arithmetic that stays correct for non-power-of-two NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= 32'(NUM_REQ))
            s = s - 32'(NUM_REQ);
        return s[ID_W-1:0];
    endfunction

    function automatic logic [DATA_W:0] add_carry(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    logic [ID_W-1:0]    rr_ptr;
    logic               vld_p1;
    logic [DATA_W-1:0]  sum_p1;
    logic               carry_p1;
    logic [ID_W-1:0]    id_p1;

    logic               accept_p0;
    logic               found_p0;
    logic [ID_W-1:0]    gnt_p0;
    logic [NUM_REQ-1:0] ready_p0;
    logic [DATA_W-1:0]  a_p0;
    logic [DATA_W-1:0]  b_p0;
    logic [DATA_W:0]    wide_p0;
    logic               grant_p0;

    // ---- Stage p0: arbitration, operand select and add ----
    assign accept_p0 = ~rst & (~vld_p1 | rsp_ready);

    always_comb begin
        logic [ID_W-1:0] idx;
        found_p0 = 1'b0;
        gnt_p0   = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = wrap_add(rr_ptr, $unsigned(k));
            if (!found_p0 && req_valid[idx]) begin
                found_p0 = 1'b1;
                gnt_p0   = idx;
            end
        end
    end

    assign grant_p0 = accept_p0 & found_p0;

    always_comb begin
        ready_p0 = '0;
        if (grant_p0)
            ready_p0[gnt_p0] = 1'b1;
    end

    assign req_ready = ready_p0;

    always_comb begin
        a_p0 = '0;
        b_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_p0 == ID_W'(i)) begin
                a_p0 = req_a[i*DATA_W +: DATA_W];
                b_p0 = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign wide_p0 = add_carry(a_p0, b_p0);

    // ---- Stage p1: response register and round-robin pointer ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            vld_p1   <= 1'b0;
            sum_p1   <= '0;
            carry_p1 <= 1'b0;
            id_p1    <= '0;
        end else if (grant_p0) begin
            {carry_p1, sum_p1} <= wide_p0;
            id_p1              <= gnt_p0;
            vld_p1             <= 1'b1;
            rr_ptr             <= wrap_add(gnt_p0, 1);
        end else if (vld_p1 && rsp_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_sum   = sum_p1;
    assign rsp_carry = carry_p1;
    assign rsp_id    = id_p1;

endmodule
